fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data word width.
REQ-002 Parameter ADDR_WIDTH, default 10, memory address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter AF_THR, default DEPTH-2, almost_full threshold.
REQ-004 Parameter AE_THR, default 2, almost_empty threshold.
REQ-005 Port clk, input, 1, single clock; all logic on rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Ports s_valid (in, 1), s_ready (out, 1), s_data (in, DATA_WIDTH): write-side valid/ready stream.
REQ-008 Ports m_valid (out, 1), m_ready (in, 1), m_data (out, DATA_WIDTH): read-side valid/ready stream, first-word-fall-through.
REQ-009 Ports mem_we (out, 1), mem_waddr (out, ADDR_WIDTH), mem_wdata (out, DATA_WIDTH): write port to the external dual-port memory.
REQ-010 Ports mem_re (out, 1), mem_raddr (out, ADDR_WIDTH), mem_rdata (in, DATA_WIDTH): read port; mem_rdata valid one cycle after mem_re and held while mem_re is low.
REQ-011 Ports count (out, ADDR_WIDTH+1), full, empty, almost_full, almost_empty (out, 1 each): status.

Function
REQ-012 Push = s_valid & s_ready; push drives mem_we=1, mem_waddr=wptr, mem_wdata=s_data combinationally in the same cycle; wptr increments after the edge.
REQ-013 s_ready = !full, with full computed from registered count only; a pop in the same cycle does not enable a push at full.
REQ-014 mem_count = words in memory not yet read-issued; rd_issue = (mem_count != 0) & (!m_valid | m_ready).
REQ-015 rd_issue drives mem_re=1, mem_raddr=rptr; rptr increments after the edge.
REQ-016 Output FSM states: IDLE (m_valid=0) and VALID (m_valid=1); IDLE->VALID on rd_issue; VALID->IDLE on pop with !rd_issue; otherwise hold.
REQ-017 m_data = mem_rdata directly; it stays stable in VALID without a pop because no read is issued.
REQ-018 Pop = m_valid & m_ready; back-to-back pops sustain one word per cycle while mem_count != 0.
REQ-019 Latency: a word pushed in cycle T into an empty FIFO appears with m_valid=1 in cycle T+2.
REQ-020 count = mem_count + m_valid, range 0..DEPTH; simultaneous push and pop leave count unchanged.
REQ-021 full = (count == DEPTH); empty = (count == 0); almost_full = (count >= AF_THR); almost_empty = (count <= AE_THR); all registered or derived from registered count.
REQ-022 wptr and rptr wrap naturally modulo DEPTH with no extra handling.
REQ-023 s_data order is preserved exactly at m_data; no word is dropped or duplicated.

Reset
REQ-024 With rst high at an edge: wptr=0, rptr=0, mem_count=0, FSM=IDLE; count=0, empty=1, full=0, almost_empty=1, almost_full=0, m_valid=0.
REQ-025 While rst is high: mem_we=0 and mem_re=0; s_ready is !full of the reset state, i.e. 1 after the first reset edge.
REQ-026 Reset mid-operation discards all buffered words; memory contents are not cleared and are never read before being rewritten.

Configuration
REQ-027 Macro FIFO_CTRL_HWM_EN defined: adds output hwm (ADDR_WIDTH+1 bits), the maximum count since reset, updated one cycle after count, reset to 0.
REQ-028 Macro FIFO_CTRL_HWM_EN undefined: hwm port and its register are absent; all other behaviour is identical.

Structure
REQ-029 Shared package fifo_ctrl_pkg holds the output FSM state enum (IDLE, VALID) and the DEPTH computation from ADDR_WIDTH.
REQ-030 fifo_ctrl has no internal sub-module; integration wrapper fifo_top instantiates fifo_ctrl and dual_port_memory.

Verification
REQ-031 ADDR_WIDTH=2: push 0x11 in cycle 0 -> mem_we=1/waddr=0 in cycle 0, mem_re=1/raddr=0 in cycle 1, m_valid=1 with m_data=0x11 in cycle 2.
REQ-032 ADDR_WIDTH=2, m_ready=0: push 5 words -> first 4 accepted, full=1 and s_ready=0 at count=4, the 5th stalls until one pop.
REQ-033 Continuous push and pop of 0..19 with m_ready=1 -> output sequence 0..19, one per cycle after the initial latency, and pointers wrap 5 times.
REQ-034 count=4 (full) with s_valid=1 and m_ready=1 -> pop occurs and push is blocked that cycle; count=3, then the push is accepted in the next cycle.
REQ-035 rst asserted with count=3 and m_valid=1 -> next cycle count=0, empty=1, m_valid=0; a new push of 0xAA is the next word out.
REQ-036 FIFO_CTRL_HWM_EN defined: fill to 3, drain to 0 -> hwm=3 and it holds after draining.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller slice: output stage state and depth math.
package fifo_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } out_state_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/dual_port_memory.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: rdata valid one cycle after re; held while re is low. No backpressure.
module dual_port_memory
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_top.sv
// Integration wrapper: fifo_ctrl plus its dual-port memory; hwm exposed when FIFO_CTRL_HWM_EN is set.
// Latency: two cycles push-to-m_valid when empty. Backpressure: s_ready low when full.
module fifo_top
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int AF_THR     = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AE_THR     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef FIFO_CTRL_HWM_EN
  ,
  output logic [ADDR_WIDTH:0]   hwm
`endif
);

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  fifo_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THR     (AF_THR),
    .AE_THR     (AE_THR)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_re       (mem_re),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef FIFO_CTRL_HWM_EN
    ,
    .hwm          (hwm)
`endif
  );

  dual_port_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller over an external 1-cycle-read dual-port memory, FWFT output; optional hwm via FIFO_CTRL_HWM_EN.
// Latency: push in cycle T into an empty FIFO shows m_valid in cycle T+2; one word per cycle sustained.
// Backpressure: s_ready = !full from registered count; a same-cycle pop never frees room for a push.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int AF_THR     = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AE_THR     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef FIFO_CTRL_HWM_EN
  ,
  output logic [ADDR_WIDTH:0]   hwm
`endif
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THR);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THR);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [0:0]            S_IDLE  = IDLE;
  localparam logic [0:0]            S_VALID = VALID;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   mem_count;
  logic [ADDR_WIDTH:0]   count_q;
  logic [0:0]            state;
  logic                  push;
  logic                  pop;
  logic                  rd_issue;

  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  assign s_ready  = !full;
  assign m_valid  = (state == S_VALID);
  assign push     = s_valid & s_ready & !rst;
  assign pop      = m_valid & m_ready & !rst;
  // mem_count excludes the word parked on m_data, so a read is issued only into a free output slot.
  assign rd_issue = (mem_count != '0) & (!m_valid | m_ready) & !rst;

  assign mem_we    = push;
  assign mem_waddr = wptr;
  assign mem_wdata = s_data;
  assign mem_re    = rd_issue;
  assign mem_raddr = rptr;
  assign m_data    = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      count_q   <= '0;
      state     <= S_IDLE;
    end else begin
      if (push)     wptr <= wptr + PTR_ONE;
      if (rd_issue) rptr <= rptr + PTR_ONE;

      case ({push, rd_issue})
        2'b10:   mem_count <= mem_count + CNT_ONE;
        2'b01:   mem_count <= mem_count - CNT_ONE;
        default: mem_count <= mem_count;
      endcase

      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase

      if (rd_issue)  state <= S_VALID;
      else if (pop)  state <= S_IDLE;
    end
  end

`ifdef FIFO_CTRL_HWM_EN
  always_ff @(posedge clk) begin
    if (rst)                hwm <= '0;
    else if (count_q > hwm) hwm <= count_q;
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (ADDR_WIDTH=2): queue-based reference model checked every cycle plus directed literal checks.
module tb_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
`ifdef FIFO_CTRL_HWM_EN
  logic [AW:0]   hwm;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_re       (mem_re),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef FIFO_CTRL_HWM_EN
    ,
    .hwm          (hwm)
`endif
  );

  // External memory: 1-cycle registered read, pre-filled with junk so stale reads are visible.
  logic [DW-1:0] mem_m [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hEE;

  always @(posedge clk) begin
    if (mem_we) mem_m[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_m[mem_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as a queue, the output register as a flag,
  // and running push/issue totals for the memory addresses.
  logic [DW-1:0] q[$];
  bit            mv_m   = 1'b0;
  bit            armed  = 1'b0;
  int            wcnt   = 0;
  int            rcnt   = 0;
  int            hwm_m  = 0;
  int            sz;
  int            memc;
  bit            push_m;
  bit            rd_m;
  bit            pop_m;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        q.delete();
        mv_m  = 1'b0;
        wcnt  = 0;
        rcnt  = 0;
        hwm_m = 0;
        armed = 1'b1;
      end else if (armed) begin
        sz     = q.size();
        memc   = sz - (mv_m ? 1 : 0);
        push_m = s_valid && (sz != DEPTH);
        rd_m   = (memc != 0) && (!mv_m || m_ready);
        pop_m  = mv_m && m_ready;

        chk("m_s_ready", {31'd0, s_ready}, {31'd0, sz != DEPTH});
        chk("m_m_valid", {31'd0, m_valid}, {31'd0, mv_m});
        if (mv_m) chk("m_m_data", {24'd0, m_data}, {24'd0, q[0]});
        chk("m_count", {29'd0, count}, sz);
        chk("m_full", {31'd0, full}, {31'd0, sz == DEPTH});
        chk("m_empty", {31'd0, empty}, {31'd0, sz == 0});
        chk("m_almost_full", {31'd0, almost_full}, {31'd0, sz >= DEPTH - 2});
        chk("m_almost_empty", {31'd0, almost_empty}, {31'd0, sz <= 2});
        chk("m_mem_we", {31'd0, mem_we}, {31'd0, push_m});
        if (push_m) begin
          chk("m_mem_waddr", {30'd0, mem_waddr}, wcnt % DEPTH);
          chk("m_mem_wdata", {24'd0, mem_wdata}, {24'd0, s_data});
        end
        chk("m_mem_re", {31'd0, mem_re}, {31'd0, rd_m});
        if (rd_m) chk("m_mem_raddr", {30'd0, mem_raddr}, rcnt % DEPTH);
`ifdef FIFO_CTRL_HWM_EN
        chk("m_hwm", {29'd0, hwm}, hwm_m);
`endif
        if (sz > hwm_m) hwm_m = sz;

        if (push_m) begin
          q.push_back(s_data);
          wcnt++;
        end
        if (rd_m) rcnt++;
        if (pop_m) void'(q.pop_front());
        if (rd_m)       mv_m = 1'b1;
        else if (pop_m) mv_m = 1'b0;
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; literal checks sample 2 units later.
  task automatic drive(input logic r, input logic v, input logic [DW-1:0] d, input logic mr);
    @(posedge clk);
    #1;
    rst     = r;
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);

    // Reset state
    drive(0, 0, 8'h00, 0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ae", {31'd0, almost_empty}, 32'd1);
    chk("rst_af", {31'd0, almost_full}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);

    // Single word latency
    drive(0, 1, 8'h11, 0);
    chk("lat_we", {31'd0, mem_we}, 32'd1);
    chk("lat_waddr", {30'd0, mem_waddr}, 32'd0);
    chk("lat_wdata", {24'd0, mem_wdata}, 32'h11);
    drive(0, 0, 8'h00, 0);
    chk("lat_re", {31'd0, mem_re}, 32'd1);
    chk("lat_raddr", {30'd0, mem_raddr}, 32'd0);
    chk("lat_mv_t1", {31'd0, m_valid}, 32'd0);
    drive(0, 0, 8'h00, 0);
    chk("lat_mv_t2", {31'd0, m_valid}, 32'd1);
    chk("lat_mdata", {24'd0, m_data}, 32'h11);
    chk("lat_count", {29'd0, count}, 32'd1);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);
    chk("lat_empty", {31'd0, empty}, 32'd1);

    // Fill to full with the sink stalled; fifth word must wait
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'h21 + 8'(i), 0);
      chk("fill_s_ready", {31'd0, s_ready}, 32'd1);
    end
    drive(0, 1, 8'h25, 0);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    chk("full_no_we", {31'd0, mem_we}, 32'd0);
    chk("full_af", {31'd0, almost_full}, 32'd1);
    drive(0, 1, 8'h25, 0);
    chk("stall_no_we", {31'd0, mem_we}, 32'd0);

    // Pop at full: push still blocked this cycle, accepted next cycle
    drive(0, 1, 8'h25, 1);
    chk("popfull_no_we", {31'd0, mem_we}, 32'd0);
    chk("popfull_mdata", {24'd0, m_data}, 32'h21);
    drive(0, 1, 8'h25, 0);
    chk("after_pop_count", {29'd0, count}, 32'd3);
    chk("after_pop_we", {31'd0, mem_we}, 32'd1);
    chk("after_pop_wdata", {24'd0, mem_wdata}, 32'h25);
    chk("after_pop_mdata", {24'd0, m_data}, 32'h22);
    repeat (8) drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Streaming 0..19 at one word per cycle
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 8'(i), 1);
      if (i >= 2) begin
        chk("stream_mv", {31'd0, m_valid}, 32'd1);
        chk("stream_mdata", {24'd0, m_data}, i - 2);
        chk("stream_count", {29'd0, count}, 32'd2);
      end
    end
    drive(0, 0, 8'h00, 1);
    chk("stream_tail18", {24'd0, m_data}, 32'd18);
    drive(0, 0, 8'h00, 1);
    chk("stream_tail19", {24'd0, m_data}, 32'd19);
    drive(0, 0, 8'h00, 0);
    chk("stream_empty", {31'd0, empty}, 32'd1);

    // Reset with buffered data discards it
    for (int i = 0; i < 3; i++) drive(0, 1, 8'h31 + 8'(i), 0);
    drive(0, 0, 8'h00, 0);
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    chk("pre_rst_mv", {31'd0, m_valid}, 32'd1);
    drive(1, 1, 8'h77, 0);
    chk("in_rst_we", {31'd0, mem_we}, 32'd0);
    chk("in_rst_re", {31'd0, mem_re}, 32'd0);
    drive(0, 0, 8'h00, 0);
    chk("post_rst_count", {29'd0, count}, 32'd0);
    chk("post_rst_empty", {31'd0, empty}, 32'd1);
    chk("post_rst_mv", {31'd0, m_valid}, 32'd0);
    drive(0, 1, 8'hAA, 0);
    chk("post_rst_waddr", {30'd0, mem_waddr}, 32'd0);
    drive(0, 0, 8'h00, 0);
    for (int k = 0; k < 5 && !m_valid; k++) drive(0, 0, 8'h00, 0);
    chk("post_rst_aa_valid", {31'd0, m_valid}, 32'd1);
    chk("post_rst_aa_data", {24'd0, m_data}, 32'hAA);
    drive(0, 0, 8'h00, 1);

    // High-water mark: fill to 3, drain to 0
    drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'h41 + 8'(i), 0);
    drive(0, 0, 8'h00, 0);
    chk("hwm_fill_count", {29'd0, count}, 32'd3);
    repeat (6) drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);
    chk("hwm_drain_count", {29'd0, count}, 32'd0);
`ifdef FIFO_CTRL_HWM_EN
    chk("hwm_after_drain", {29'd0, hwm}, 32'd3);
`endif

    drive(0, 0, 8'h00, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
